// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM among N_REQ requesters.
// Stage 1 selects a winner from req & ~gnt, then registers a one-hot gnt and
// the winner's address onto rom_addr. Stage 2 flags the returned word one
// cycle later and tags it with the winner index.
// Build option: define FONT_ARB_FIXED_PRIO_EN for fixed priority (req[0]
// highest). Leave it undefined for round-robin with a rotating pointer.
module font_rom_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic                    rd_valid,
   output logic [1:0]              rd_id,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    busy
);

   logic [N_REQ-1:0]  gnt_d,      gnt_q;
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
   logic [1:0]        win_d,      win_q;      // index behind the current gnt
   logic              rd_valid_d, rd_valid_q;
   logic [1:0]        rd_id_d,    rd_id_q;
   logic              busy_d,     busy_q;

   logic [N_REQ-1:0]  eligible_s;
   logic              found_s;
   logic              hit_s;
   logic [1:0]        win_s;
   logic [1:0]        cand_s;
   logic [ADDR_W-1:0] addr_s [N_REQ];
`ifndef FONT_ARB_FIXED_PRIO_EN
   logic [1:0]        ptr_d,      ptr_q;
`endif

   // Winner search: the first eligible requester in search order.
   // A requester granted last cycle is masked so one held request is served once.
   always_comb begin
      eligible_s = req & ~gnt_q;
      found_s    = 1'b0;
      hit_s      = 1'b0;
      win_s      = 2'd0;
      cand_s     = 2'd0;
      for (int i = 0; i < N_REQ; i++) begin
`ifdef FONT_ARB_FIXED_PRIO_EN
         cand_s  = 2'(i);
`else
         cand_s  = ptr_q + 2'(i);
`endif
         hit_s   = !found_s && eligible_s[cand_s];
         win_s   = hit_s ? cand_s : win_s;
         found_s = found_s | hit_s;
      end
   end

   // Stage-1 next state: the grant pulse, the winner address, and the pointer update.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         addr_s[i] = req_addr[i*ADDR_W +: ADDR_W];
      end
      gnt_d      = {N_REQ{1'b0}};
      rom_addr_d = rom_addr_q;
      win_d      = win_q;
`ifndef FONT_ARB_FIXED_PRIO_EN
      ptr_d      = ptr_q;
`endif
      if (found_s) begin
         gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
         rom_addr_d = addr_s[win_s];
         win_d      = win_s;
`ifndef FONT_ARB_FIXED_PRIO_EN
         ptr_d      = win_s + 2'd1;
`endif
      end else begin
         gnt_d      = {N_REQ{1'b0}};
         rom_addr_d = rom_addr_q;
      end
   end

   // Stage-2 next state: the ROM answers one cycle after the grant, so tag that cycle.
   always_comb begin
      rd_valid_d = |gnt_q;
      rd_id_d    = rd_id_q;
      if (|gnt_q) begin
         rd_id_d = win_q;
      end else begin
         rd_id_d = rd_id_q;
      end
      busy_d = (|gnt_d) | rd_valid_d;
   end

   // Pipeline registers. Reset drops in-flight reads and restarts the pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q      <= {N_REQ{1'b0}};
         rom_addr_q <= {ADDR_W{1'b0}};
         win_q      <= 2'd0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= 2'd0;
         busy_q     <= 1'b0;
`ifndef FONT_ARB_FIXED_PRIO_EN
         ptr_q      <= 2'd0;
`endif
      end else begin
         gnt_q      <= gnt_d;
         rom_addr_q <= rom_addr_d;
         win_q      <= win_d;
         rd_valid_q <= rd_valid_d;
         rd_id_q    <= rd_id_d;
         busy_q     <= busy_d;
`ifndef FONT_ARB_FIXED_PRIO_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   // Pass the ROM word through only while it belongs to a granted read.
   always_comb begin
      if (rd_valid_q) begin
         rd_data = rom_data;
      end else begin
         rd_data = {DATA_W{1'b0}};
      end
   end

   assign gnt      = gnt_q;
   assign rom_addr = rom_addr_q;
   assign rd_valid = rd_valid_q;
   assign rd_id    = rd_id_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter. It uses a vector table of single-cycle
// requests plus hand-written multi-cycle sequences. Returned words go through
// a scoreboard queue. A behavioural synchronous ROM drives rom_data.
module tb_font_rom_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [43:0] req_addr;
   logic [3:0]  gnt;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rd_valid;
   logic [1:0]  rd_id;
   logic [7:0]  rd_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  req;
      logic [10:0] base;
      int          win_rr;
      int          win_fp;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   vec_t tbl [10];
   exp_t sb_q [$];

   font_rom_arbiter #(.N_REQ(4), .ADDR_W(11), .DATA_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_addr (req_addr),
      .gnt      (gnt),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rd_valid (rd_valid),
      .rd_id    (rd_id),
      .rd_data  (rd_data),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(input logic [10:0] a);
      return a[7:0] ^ {1'b0, a[10:4]} ^ 8'h5A;
   endfunction

   // Synchronous ROM: the word for the current rom_addr appears one clock later.
   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addrs(input logic [10:0] base);
      for (int i = 0; i < 4; i++) req_addr[i*11 +: 11] = base + 11'(i);
   endtask

   task automatic push_exp(input int id, input logic [10:0] a);
      exp_t e;
      e.id   = 2'(id);
      e.data = rom_fn(a);
      sb_q.push_back(e);
   endtask

   // Scoreboard side: each rd_valid pops one expected word; otherwise rd_data must be zero.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rd_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("rd_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("rd_id", 32'(rd_id), 32'(e.id));
            chk("rd_data", 32'(rd_data), 32'(e.data));
         end
      end else begin
         chk("rd_data_idle", 32'(rd_data), 32'd0);
      end
   end

   initial begin
      int          win;
      int          last_id;
      logic [10:0] last_addr;
      logic [10:0] exp_addr;
      logic [3:0]  exp_gnt;
      logic [3:0]  pat;
      int          ida;
      int          idb;

      // win_rr assumes the pointer starts at 0 after reset; -1 means no grant
      tbl[0] = '{req: 4'b0001, base: 11'h100, win_rr: 0,  win_fp: 0};
      tbl[1] = '{req: 4'b0001, base: 11'h200, win_rr: 0,  win_fp: 0};
      tbl[2] = '{req: 4'b1001, base: 11'h300, win_rr: 3,  win_fp: 0};
      tbl[3] = '{req: 4'b1010, base: 11'h400, win_rr: 1,  win_fp: 1};
      tbl[4] = '{req: 4'b1010, base: 11'h500, win_rr: 3,  win_fp: 1};
      tbl[5] = '{req: 4'b0100, base: 11'h506, win_rr: 2,  win_fp: 2};
      tbl[6] = '{req: 4'b0000, base: 11'h600, win_rr: -1, win_fp: -1};
      tbl[7] = '{req: 4'b0111, base: 11'h700, win_rr: 0,  win_fp: 0};
      tbl[8] = '{req: 4'b0110, base: 11'h7F0, win_rr: 1,  win_fp: 1};
      tbl[9] = '{req: 4'b1111, base: 11'h0FC, win_rr: 2,  win_fp: 0};

      // Reset, then 3 idle cycles
      reset    = 1'b1;
      req      = 4'b0000;
      req_addr = 44'h0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);

      // Vector table: one-cycle request, grant next cycle, word the cycle after
      last_id   = 0;
      last_addr = 11'h000;
      for (int r = 0; r < 10; r++) begin
`ifdef FONT_ARB_FIXED_PRIO_EN
         win = tbl[r].win_fp;
`else
         win = tbl[r].win_rr;
`endif
         req = tbl[r].req;
         set_addrs(tbl[r].base);
         if (win >= 0) begin
            exp_addr = tbl[r].base + 11'(win);
            exp_gnt  = 4'b0001 << win;
            push_exp(win, exp_addr);
         end else begin
            exp_addr = last_addr;
            exp_gnt  = 4'b0000;
         end
         tick();
         chk($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(exp_gnt));
         chk($sformatf("tbl%0d_rom_addr", r), 32'(rom_addr), 32'(exp_addr));
         chk($sformatf("tbl%0d_busy1", r), 32'(busy), (win >= 0) ? 32'd1 : 32'd0);
         chk($sformatf("tbl%0d_rd_id_hold", r), 32'(rd_id), 32'(last_id));
         req = 4'b0000;
         tick();
         chk($sformatf("tbl%0d_rd_valid", r), 32'(rd_valid), (win >= 0) ? 32'd1 : 32'd0);
         chk($sformatf("tbl%0d_busy2", r), 32'(busy), (win >= 0) ? 32'd1 : 32'd0);
         chk($sformatf("tbl%0d_gnt_off", r), 32'(gnt), 32'd0);
         if (win >= 0) begin
            last_id   = win;
            last_addr = exp_addr;
         end
      end

      // Round-robin sweep from pointer 0: each requester drops req after its grant
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_addrs(11'h3C0);
      req = 4'b1111;
      for (int k = 0; k < 4; k++) push_exp(k, 11'h3C0 + 11'(k));
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << k));
         chk($sformatf("rr_rd_valid%0d", k), 32'(rd_valid), (k != 0) ? 32'd1 : 32'd0);
         req[k] = 1'b0;
      end
      tick();
      chk("rr_gnt_end", 32'(gnt), 32'd0);
      chk("rr_rd_valid_last", 32'(rd_valid), 32'd1);
      tick();
      chk("rr_rd_valid_end", 32'(rd_valid), 32'd0);
      chk("rr_busy_end", 32'(busy), 32'd0);

      // Two requesters held continuously must alternate
`ifdef FONT_ARB_FIXED_PRIO_EN
      pat = 4'b1010;
      ida = 1;
      idb = 3;
`else
      pat = 4'b0011;
      ida = 0;
      idb = 1;
`endif
      set_addrs(11'h2A0);
      req = pat;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) push_exp(ida, 11'h2A0 + 11'(ida));
         else            push_exp(idb, 11'h2A0 + 11'(idb));
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("alt_gnt%0d", k), 32'(gnt),
             (k % 2 == 0) ? 32'(4'b0001 << ida) : 32'(4'b0001 << idb));
      end
      req = 4'b0000;
      tick();
      chk("alt_gnt_end", 32'(gnt), 32'd0);
      tick();
      tick();
      chk("alt_busy_end", 32'(busy), 32'd0);

      // Mid-flight reset: the granted read must vanish and the pointer restart at 0
      set_addrs(11'h444);
      req = 4'b0100;
      tick();
      chk("mfr_gnt", 32'(gnt), 32'(4'b0100));
      req   = 4'b0000;
      reset = 1'b1;
      tick();
      chk("mfr_rd_valid_a", 32'(rd_valid), 32'd0);
      chk("mfr_busy_a", 32'(busy), 32'd0);
      chk("mfr_gnt_a", 32'(gnt), 32'd0);
      reset = 1'b0;
      tick();
      chk("mfr_rd_valid_b", 32'(rd_valid), 32'd0);
      chk("mfr_busy_b", 32'(busy), 32'd0);
      set_addrs(11'h111);
      req = 4'b1111;
      push_exp(0, 11'h111);
      tick();
      chk("mfr_ptr_restart", 32'(gnt), 32'(4'b0001));
      chk("mfr_rom_addr", 32'(rom_addr), 32'(11'h111));
      req = 4'b0000;
      tick();
      chk("mfr_rd_valid_c", 32'(rd_valid), 32'd1);
      tick();
      tick();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/font_rom_arbiter.md
FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters; the value is fixed at 4 in this revision.
REQ-002 The block SHALL have parameter ADDR_W, default 11, the font ROM address width, {char[6:0], row[3:0]}.
REQ-003 The block SHALL have parameter DATA_W, default 8, the font ROM word width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port req, input, 4, per-requester read request, held until granted.
REQ-007 The block SHALL have port req_addr, input, 44, packed addresses; requester i uses bits [11i+10:11i], held stable while req[i] is high.
REQ-008 The block SHALL have port gnt, output, 4, one-hot grant pulse, registered.
REQ-009 The block SHALL have port rom_addr, output, 11, address to font_rom, registered.
REQ-010 The block SHALL have port rom_data, input, 8, font_rom data, valid one clk after rom_addr.
REQ-011 The block SHALL have port rd_valid, output, 1, which flags that the returned font word is valid.
REQ-012 The block SHALL have port rd_id, output, 2, the index of the requester that owns rd_data.
REQ-013 The block SHALL have port rd_data, output, 8, the returned font word.
REQ-014 The block SHALL have port busy, output, 1, high while any read is in flight.

Function
REQ-015 In cycle N the block SHALL select at most one winner from eligible = req & ~gnt, so a requester is never granted twice for one held request.
REQ-016 If eligible is non-zero in cycle N, then in cycle N+1 gnt SHALL be one-hot for the winner and rom_addr SHALL equal that winner's req_addr slice from cycle N.
REQ-017 If eligible is zero, gnt SHALL be 0 in N+1 and rom_addr SHALL hold its previous value.
REQ-018 In round-robin mode, search order SHALL start at pointer ptr (2 bits) and wrap 3->0; after a grant, ptr SHALL become winner+1 mod 4; without a grant, ptr SHALL be unchanged.
REQ-019 In cycle N+2 after the grant, rd_valid SHALL be 1, rd_id SHALL equal the winner index and rd_data SHALL equal rom_data, giving a fixed latency of 2 from the request-sample cycle.
REQ-020 When rd_valid is 0, rd_data SHALL be 8'h00 and rd_id SHALL hold its last value.
REQ-021 Throughput SHALL be one grant per cycle across different requesters and at most one grant per 2 cycles for a single continuously requesting requester.
REQ-022 The block SHALL pipeline grants back-to-back with no bubbles; rd_valid SHALL be high in consecutive cycles for consecutive grants.
REQ-023 busy SHALL be the OR of stage-1 valid (gnt != 0) and stage-2 valid (rd_valid).
REQ-024 A requester that drops req before it is granted SHALL be withdrawn with no side effect.
REQ-025 req_addr SHALL be sampled only for the winner, in the cycle of selection.

Reset
REQ-026 While reset is high at a clk edge, the block SHALL set gnt=0, rom_addr=0, rd_valid=0, rd_id=0, ptr=0, and busy=0; rd_data is 0 as a consequence of rd_valid=0.
REQ-027 When reset is asserted mid-operation, in-flight reads SHALL be discarded with no rd_valid for them; the first grant is possible in the cycle after reset deasserts and becomes visible one cycle later.

Configuration
REQ-028 When macro FONT_ARB_FIXED_PRIO_EN is defined, the block SHALL use fixed priority (req[0] highest, req[3] lowest) and SHALL not implement ptr; when it is undefined, the block SHALL use the round-robin behaviour of REQ-018.

Verification
REQ-029 Reset check: after reset and then idle for 3 cycles, gnt, rd_valid, busy, rom_addr and rd_data SHALL all be 0.
REQ-030 Single read: req=4'b0100 with slice2=11'h508 ("P" row 8) in cycle 0 -> gnt=4'b0100 and rom_addr=11'h508 in cycle 1; rd_valid=1, rd_id=2 and rd_data=rom_data in cycle 2.
REQ-031 Round-robin: req=4'b1111 held, each requester dropping req after its gnt -> grant order 0,1,2,3 on consecutive cycles, with 4 consecutive rd_valid pulses carrying rd_id 0,1,2,3.
REQ-032 Fairness: req[0] and req[1] held continuously -> grants alternate 0,1,0,1, and no requester is granted in two adjacent cycles.
REQ-033 Fixed priority (macro defined): req=4'b1010 held -> requester 1 is granted on every other cycle; requester 3 is granted only in the cycles where requester 1 is masked.
REQ-034 Mid-flight reset: grant in cycle 1 and reset high in cycle 2 -> no rd_valid in cycles 2-4, busy=0 from cycle 3, and ptr restarts at 0.
